sequenciador_controle: RTL

//  Parametrised, microcode-driven control unit; successor to the fixed hard-wired step FSM.

---
 rtl/sequenciador_controle.sv | 107 ++++++++++
 1 files changed

// File: rtl/sequenciador_controle.sv
// Microcode-driven control sequencer: plays a programmable table of control words, repeats it reps times.
// Optional macro CTRL_SINGLE_STEP_EN adds a step_en input that gates advancement in RUN.
module sequenciador_controle #(
    parameter  int N_STEPS = 8,
    parameter  int CW_W    = 10,
    parameter  int REP_W   = 4,
    localparam int AW      = $clog2(N_STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inicio,
    input  logic [REP_W-1:0]  reps,
    input  logic              abort,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic              step_en,
`endif
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [CW_W:0]     prog_data,
    output logic              prog_err,
    output logic [CW_W-1:0]   ctrl,
    output logic [AW-1:0]     step_idx,
    output logic              busy,
    output logic              pronto
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AW:0]   DEPTH = (AW+1)'(N_STEPS);
    localparam logic [AW-1:0] LAST  = AW'(N_STEPS - 1);

    state_t                     state, state_nxt;
    logic [AW-1:0]              step, step_nxt;
    logic [REP_W-1:0]           rep_cnt, rep_nxt;
    logic [N_STEPS-1:0][CW_W:0] tbl;
    logic                       adv, pass_end, wr_ok;

`ifdef CTRL_SINGLE_STEP_EN
    assign adv = step_en;
`else
    assign adv = 1'b1;
`endif

    // Writes only land while idle, so a running pass never sees a word change under it.
    assign wr_ok    = prog_we && (state == IDLE) && ({1'b0, prog_addr} < DEPTH);
    assign pass_end = tbl[step][CW_W] || (step == LAST);

    assign ctrl     = (state == RUN) ? tbl[step][CW_W-1:0] : '0;
    assign step_idx = step;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        rep_nxt   = rep_cnt;
        case (state)
            IDLE: begin
                if (inicio && !abort) begin
                    state_nxt = RUN;
                    step_nxt  = '0;
                    rep_nxt   = (reps == '0) ? REP_W'(1) : reps;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    step_nxt  = '0;
                end else if (adv) begin
                    if (!pass_end) begin
                        step_nxt = step + AW'(1);
                    end else if (rep_cnt > REP_W'(1)) begin
                        // Wrap straight back to word 0 so consecutive passes have no gap.
                        rep_nxt  = rep_cnt - REP_W'(1);
                        step_nxt = '0;
                    end else begin
                        state_nxt = DONE;
                        step_nxt  = '0;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            step     <= '0;
            rep_cnt  <= '0;
            pronto   <= 1'b0;
            prog_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            rep_cnt  <= rep_nxt;
            pronto   <= (state_nxt == DONE);
            prog_err <= prog_we && !wr_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        tbl            <= '0;
        else if (wr_ok) tbl[prog_addr] <= prog_data;
    end

endmodule
